alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Registered output stage directly downstream of n_bit_alu_four.
- Captures each ALU result together with its zero flag and 4-bit control tag into a small FIFO.
- Presents the oldest entry to the consumer (writeback/register-file side) over a valid/ready handshake.
- Decouples the combinational ALU from consumer stalls and flags dropped results and unsupported opcodes.

Parameters:
- n, 32, datapath width; must match the n of the ALU that feeds this block.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  buffer can accept; equals !full
- in_result  input  n  ALU_Result from n_bit_alu_four
- in_zero  input  1  zero flag from n_bit_alu_four
- in_control  input  4  opcode that produced the result
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts head entry
- out_result  output  n  head entry result
- out_zero  output  1  head entry zero flag
- out_control  output  4  head entry opcode
- out_illegal  output  1  head entry opcode greater than 4'b1010
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was attempted while full
- clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0.
  - overflow goes to 0; out_valid goes to 0; in_ready goes to 1.
  - out_result, out_zero, out_control and out_illegal read 0; a masked head is acceptable.
  - Storage contents are don't-care.
- Reset mid-transfer: all in-flight entries are discarded. Nothing is replayed after rst_n rises.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - Writes {in_control, in_zero, in_result} to mem[wr_ptr]; wr_ptr advances.
- Pop:
  - Occurs when out_valid && out_ready at a rising edge; rd_ptr advances.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count rules:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- full = (count==DEPTH); empty = (count==0).
- in_ready = !full, combinational from registered count.
  - When full, a push is refused even if a pop occurs in the same cycle; in_ready does not depend on out_ready.
- First-word fall-through:
  - out_valid = !empty.
  - out_* are driven from mem[rd_ptr].
  - A push into an empty buffer is visible on out_valid/out_* on the cycle after the push edge (1-cycle latency).
  - No bypass from input to output.
- Output stability: while out_valid && !out_ready, all out_* hold their values.
- out_illegal = (out_control > 4'b1010), decoded from the stored tag. The entry is still delivered normally.
- Pop attempts:
  - Pop on empty (out_ready high, out_valid low) is ignored; no pointer or count change.
  - When count==1, a simultaneous push and pop leaves count=1, and the new entry becomes head on the next cycle.
- overflow:
  - Set at any edge where in_valid && full; the data is dropped and no state changes.
  - Cleared at an edge where clear_ovf is high.
  - If set and clear happen in the same cycle, set wins.
- No X propagation from storage: out_* may read stale data while out_valid=0, and the bench must not check them then.

Optional Feature:
- Macro: ALU_ZERO_STAT_EN
- Defined: adds output zero_cnt [15:0].
  - Reset value is 0.
  - Increments on every pop whose head has out_zero=1.
  - Saturates at 16'hFFFF.
  - Cleared by clear_ovf; if a clear and an increment happen in the same cycle, the clear wins.
- Undefined: zero_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single push, empty buffer:
  - Stimulus: after reset, push {ctrl=4'b0000, result=32'd27, zero=0} with out_ready=0.
  - Required: out_valid rises the next cycle; out_result=27; count=1; out_illegal=0.
- Fill with consumer stalled:
  - Stimulus: push 4 entries with out_ready=0; results 32'd3, 32'd46001, 32'd0 (zero=1), 32'd48565644.
  - Required: count=4 and in_ready=0.
  - Then out_ready=1: entries pop in order; out_zero=1 only on the third; count returns to 0 and out_valid drops.
- Overflow:
  - Stimulus: with the buffer full, hold in_valid=1 for 2 cycles.
  - Required: overflow=1 and stays high; FIFO contents unchanged.
  - Then clear_ovf=1 for 1 cycle: overflow=0. clear_ovf and in_valid both asserted while full: overflow stays 1.
- Simultaneous push and pop:
  - Stimulus: at count=2, in_valid=1 and out_ready=1 for 6 cycles.
  - Required: count stays 2; 6 pops observed in push order; pointer wrap-around exercised.
- Illegal opcode:
  - Stimulus: push ctrl=4'b1011, then ctrl=4'b1111.
  - Required: out_illegal=1 for both entries; results are delivered unchanged.
- Reset mid-operation:
  - Stimulus: with count=3, assert rst_n=0 mid-cycle.
  - Required: out_valid=0 and count=0 immediately (asynchronously); in_ready=1.
  - With ALU_ZERO_STAT_EN defined: zero_cnt=0 after reset, and it increments by 1 per zero-flag pop.

Source files
------------

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Registered output stage behind n_bit_alu_four. It stores each ALU result
//   together with its zero flag and 4-bit opcode tag in a small first-word
//   fall-through FIFO. The oldest entry is offered to the writeback side over
//   a valid/ready handshake.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ready = !full
//   in_result/in_zero/in_control   ALU result, zero flag, opcode
//   out_valid/out_ready            downstream handshake
//   out_result/out_zero/out_control  head entry (reads 0 while empty)
//   out_illegal       head opcode is above 4'b1010
//   count             occupancy, 0..DEPTH
//   overflow          sticky flag: a push was attempted while full
//   clear_ovf         synchronous clear of overflow (and of zero_cnt)
//
// Optional build macro ALU_ZERO_STAT_EN:
//   adds zero_cnt[15:0], a saturating count of popped entries whose zero
//   flag is set. It is cleared by clear_ovf, and the clear wins over an
//   increment in the same cycle.
module alu_result_buffer #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             in_result,
  input  logic                     in_zero,
  input  logic [3:0]               in_control,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [n-1:0]             out_result,
  output logic                     out_zero,
  output logic [3:0]               out_control,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
`ifdef ALU_ZERO_STAT_EN
  ,
  output logic [15:0]              zero_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = n + 5;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign out_valid = !empty;

  // A full buffer refuses a push even if a pop happens in the same cycle.
  // This keeps in_ready independent of out_ready.
  assign push = in_valid && !full;
  assign pop  = out_valid && out_ready;

  // Storage is not reset. The head is masked while the buffer is empty, so
  // stale or uninitialised entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_control, in_zero, in_result};
    end
  end

  assign head        = mem[rd_ptr];
  assign out_result  = out_valid ? head[n-1:0]   : '0;
  assign out_zero    = out_valid & head[n];
  assign out_control = out_valid ? head[n+4:n+1] : 4'h0;
  assign out_illegal = (out_control > 4'b1010);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // When a drop and a clear coincide, the drop takes priority. This keeps
  // the flag from losing an event that arrived in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid && full) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef ALU_ZERO_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (clear_ovf) begin
      zero_cnt <= '0;
    end else if (pop && out_zero && (zero_cnt != 16'hFFFF)) begin
      zero_cnt <= zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]   ctrl;
    logic         zero;
    logic [N-1:0] res;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_result = '0;
  logic         in_zero = 1'b0;
  logic [3:0]   in_control = 4'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_result;
  logic         out_zero;
  logic [3:0]   out_control;
  logic         out_illegal;
  logic [2:0]   count;
  logic         overflow;
  logic         clear_ovf = 1'b0;
`ifdef ALU_ZERO_STAT_EN
  logic [15:0]  zero_cnt;
`endif

  alu_result_buffer #(.n(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_control  (in_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_control (out_control),
    .out_illegal (out_illegal),
    .count       (count),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
`ifdef ALU_ZERO_STAT_EN
    ,
    .zero_cnt    (zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // mq is the reference FIFO contents. sb holds the entries the monitor
  // still expects to see delivered.
  ent_t        mq[$];
  ent_t        sb[$];
  logic        m_ovf = 1'b0;
  int unsigned m_zc  = 0;
  logic        m_push;
  logic        m_pop;
  ent_t        m_head;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated at the same edge the DUT uses.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      m_ovf = 1'b0;
      m_zc  = 0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = out_ready && (mq.size() > 0);
      if (in_valid && mq.size() == DEPTH) m_ovf = 1'b1;
      else if (clear_ovf)                 m_ovf = 1'b0;
      if (m_pop) begin
        m_head = mq.pop_front();
        if (clear_ovf) m_zc = 0;
        else if (m_head.zero && m_zc != 32'hFFFF) m_zc = m_zc + 1;
      end else if (clear_ovf) begin
        m_zc = 0;
      end
      if (m_push) begin
        mq.push_back('{ctrl: in_control, zero: in_zero, res: in_result});
        sb.push_back('{ctrl: in_control, zero: in_zero, res: in_result});
      end
    end
  end

  // Monitor: compares the presented head against the scoreboard on the
  // falling edge, and retires it when the consumer accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count", 64'(count), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef ALU_ZERO_STAT_EN
      check("zero_cnt", 64'(zero_cnt), 64'(m_zc));
`endif
      if (out_valid && sb.size() > 0) begin
        check("out_result", 64'(out_result), 64'(sb[0].res));
        check("out_zero", 64'(out_zero), 64'(sb[0].zero));
        check("out_control", 64'(out_control), 64'(sb[0].ctrl));
        check("out_illegal", 64'(out_illegal), 64'(sb[0].ctrl > 4'd10));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] r, input logic z,
                       input logic [3:0] c, input logic rdy, input logic clr);
    in_valid   = v;
    in_result  = r;
    in_zero    = z;
    in_control = c;
    out_ready  = rdy;
    clear_ovf  = clr;
  endtask

  initial begin
    logic [N-1:0] rr;
    logic         zz;

    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
`ifdef ALU_ZERO_STAT_EN
    check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
`endif
    #10 rst_n = 1'b1;

    // Single push into an empty buffer.
    drive(1, 32'd27, 0, 4'b0000, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_result", 64'(out_result), 64'd27);
    check("single_count", 64'(count), 64'd1);
    check("single_illegal", 64'(out_illegal), 64'd0);
    drive(0, 0, 0, 0, 1, 0);
    step();
    check("single_drained", 64'(count), 64'd0);

    // Fill with the consumer stalled.
    drive(1, 32'd3, 0, 4'd0, 0, 0);        step();
    drive(1, 32'd46001, 0, 4'd1, 0, 0);    step();
    drive(1, 32'd0, 1, 4'd2, 0, 0);        step();
    drive(1, 32'd48565644, 0, 4'd3, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);

    // Overflow while full: the data is dropped and the flag sticks.
    drive(1, 32'd99, 0, 4'd5, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    drive(0, 0, 0, 0, 0, 1);
    step();
    check("ovf_clear", 64'(overflow), 64'd0);
    drive(1, 32'd77, 0, 4'd0, 0, 1);
    step();
    check("ovf_set_wins", 64'(overflow), 64'd1);
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step();
    drive(0, 0, 0, 0, 0, 0);
    check("fill_drain_count", 64'(count), 64'd0);
    check("fill_drain_valid", 64'(out_valid), 64'd0);

    // Simultaneous push and pop at count=2; the pointers wrap.
    drive(1, 32'd100, 0, 4'd4, 0, 0); step();
    drive(1, 32'd101, 0, 4'd5, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'(200 + i), (i == 2), 4'(i), 1, 0);
      step();
      check("pp_count", 64'(count), 64'd2);
    end
    drive(0, 0, 0, 0, 1, 0);
    step();
    step();
    check("pp_drained", 64'(count), 64'd0);

    // Illegal opcodes are flagged but delivered normally.
    drive(1, 32'hDEAD, 0, 4'b1011, 0, 0);
    step();
    check("illegal_b", 64'(out_illegal), 64'd1);
    drive(1, 32'hBEEF, 0, 4'b1111, 1, 0);
    step();
    check("illegal_f", 64'(out_illegal), 64'd1);
    check("illegal_f_res", 64'(out_result), 64'hBEEF);
    drive(0, 0, 0, 0, 1, 0);
    step();

    // Asynchronous reset with three entries in flight.
    drive(1, 32'd1, 1, 4'd1, 0, 0); step();
    drive(1, 32'd2, 0, 4'd2, 0, 0); step();
    drive(1, 32'd3, 0, 4'd3, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_rst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_ZERO_STAT_EN
    check("mid_rst_zero_cnt", 64'(zero_cnt), 64'd0);
`endif
    #10 rst_n = 1'b1;
    step();
    check("post_rst_valid", 64'(out_valid), 64'd0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      zz = ($urandom_range(0, 3) == 0);
      rr = zz ? '0 : $urandom();
      drive($urandom_range(0, 3) != 0, rr, zz, 4'($urandom_range(0, 15)),
            (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step();
    check("final_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
